inst_sram_resp: RTL and testbench
=================================

INST_SRAM_RESP -- requirements
Module: inst_sram_resp

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, meaning word-index width (DEPTH = 2^ADDR_WIDTH 32-bit words).
REQ-002 SHALL have parameter BASE_ADDR, default 32'hbfc00000, meaning byte address of word 0, aligned to 4*DEPTH.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port inst_sram_en  input  1  access request this cycle.
REQ-006 SHALL have port inst_sram_wen  input  4  byte write enables, bit i covers wdata[8i+7:8i].
REQ-007 SHALL have port inst_sram_addr  input  32  byte address.
REQ-008 SHALL have port inst_sram_wdata  input  32  write data.
REQ-009 SHALL have port inst_sram_rdata  output  32  read data, registered.
REQ-010 SHALL have port init_done  output  1  high once memory clear completes.
REQ-011 SHALL have port addr_err  output  1  sticky flag, bad address seen.

Function
REQ-012 SHALL implement FSM states INIT and READY; INIT entered on reset.
REQ-013 In INIT, SHALL write zero to word cnt each cycle, cnt counting 0..DEPTH-1, then move to READY; clear takes exactly DEPTH cycles after reset release.
REQ-014 init_done SHALL be low in INIT, high in READY; FSM never returns to INIT except via reset.
REQ-015 In INIT, requests SHALL be ignored: writes dropped, rdata loaded with 0 if en high.
REQ-016 Address in range iff BASE_ADDR <= addr < BASE_ADDR+4*DEPTH and addr[1:0]==0; word index = addr[ADDR_WIDTH+1:2].
REQ-017 Read: en high, wen==0, in range, READY -> rdata = mem[index] on the next rising edge (1-cycle latency, no stall, no ready signal).
REQ-018 Write: en high, wen!=0, in range, READY -> only enabled bytes of mem[index] updated on that edge; disabled bytes unchanged.
REQ-019 rdata SHALL update only on cycles with en high; with en low it holds its last value indefinitely.
REQ-020 Out-of-range or misaligned access with en high (READY) -> no memory change, rdata loaded with 0, addr_err set on the same edge.
REQ-021 addr_err SHALL stay high until reset; never set in INIT or when en low.
REQ-022 Back-to-back accesses every cycle SHALL be supported at full throughput, any mix of read/write.

Reset
REQ-023 On resetn low, asynchronously: state=INIT, cnt=0, inst_sram_rdata=0, addr_err=0, init_done=0.
REQ-024 Reset asserted mid-INIT or mid-access SHALL abort it; clear restarts from word 0 after release.
REQ-025 Memory array itself SHALL NOT be reset asynchronously; zeroing comes only from INIT.

Configuration
REQ-026 Macro INST_SRAM_WRITE_FIRST_EN SHALL select write-cycle rdata behaviour.
REQ-027 With INST_SRAM_WRITE_FIRST_EN defined: write cycle loads rdata with merged new word (enabled bytes new, others old).
REQ-028 Without it: write cycle loads rdata with old mem[index] (read-first).

Verification
REQ-029 Release reset, hold en=0 -> init_done rises exactly 4096 cycles later (ADDR_WIDTH=12); rdata=0 throughout.
REQ-030 After init, read 0xbfc00000 -> rdata=0x00000000 next cycle; write wen=4'hf data 0x3c1d0000 to 0xbfc00004, read it -> 0x3c1d0000.
REQ-031 Word 0xbfc00008=0x11223344, write wen=4'b0101 data 0xaabbccdd -> write cycle rdata 0x11bb33dd with macro, 0x11223344 without; subsequent read 0x11bb33dd.
REQ-032 Read 0xbfc00002 then 0xbfbffffc -> rdata=0 each, addr_err=1 after first, stays 1; memory unchanged; en=0 next cycles -> rdata holds 0.
REQ-033 Assert resetn low at cnt=100 during INIT and during a write -> rdata=0, addr_err=0 immediately; after release init_done after full 4096 cycles, previously written word reads 0.

Source files
------------

// File: rtl/inst_sram_resp_if.sv
// inst_sram_resp_if: instruction SRAM request/response bus.
interface inst_sram_resp_if;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  modport master (output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata, input inst_sram_rdata);
  modport slave (input inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata, output inst_sram_rdata);
endinterface

// File: rtl/inst_sram_resp.sv
// inst_sram_resp: instruction SRAM that zero-clears itself after reset and flags bad addresses.
// Macro INST_SRAM_WRITE_FIRST_EN: write cycles return the merged new word instead of the old word.
module inst_sram_resp #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'hbfc00000
) (
  input  logic            clk,
  input  logic            resetn,
  inst_sram_resp_if.slave bus,
  output logic            init_done,
  output logic            addr_err
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'd1 << (ADDR_WIDTH + 2));
`ifdef INST_SRAM_WRITE_FIRST_EN
  localparam bit WRITE_FIRST = 1'b1;
`else
  localparam bit WRITE_FIRST = 1'b0;
`endif
  typedef enum logic {INIT, READY} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d, idx;
  logic [31:0]           mem_q [DEPTH];
  logic [31:0]           rdata_q, rdata_d, old_word, new_word;
  logic                  addr_err_q, addr_err_d, in_range, wr;
  always_comb begin
    idx = bus.inst_sram_addr[ADDR_WIDTH+1:2];
    in_range = {1'b0, bus.inst_sram_addr} >= {1'b0, BASE_ADDR} &&
               {1'b0, bus.inst_sram_addr} < END_ADDR && bus.inst_sram_addr[1:0] == 2'b00;
    old_word = mem_q[idx];
    new_word = old_word;
    for (int i = 0; i < 4; i++)
      if (bus.inst_sram_wen[i]) new_word[8*i +: 8] = bus.inst_sram_wdata[8*i +: 8];
    wr = state_q == READY && bus.inst_sram_en && |bus.inst_sram_wen && in_range;
    state_d = (state_q == INIT && cnt_q == '1) ? READY : state_q;
    cnt_d = state_q == INIT ? cnt_q + 1'b1 : cnt_q;
    // INIT and bad addresses both return zero; only en-high cycles touch rdata
    rdata_d = !bus.inst_sram_en ? rdata_q :
              (state_q == INIT || !in_range) ? 32'h0 :
              (WRITE_FIRST && |bus.inst_sram_wen) ? new_word : old_word;
    addr_err_d = addr_err_q | (state_q == READY && bus.inst_sram_en && !in_range);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      rdata_q    <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      addr_err_q <= addr_err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (state_q == INIT) mem_q[cnt_q] <= '0;
    else if (wr) mem_q[idx] <= new_word;
  end
  assign bus.inst_sram_rdata = rdata_q;
  assign init_done = state_q == READY;
  assign addr_err = addr_err_q;
endmodule

// File: tb/tb_inst_sram_resp.sv
// tb_inst_sram_resp: directed and random traffic against a word-array reference model.
module tb_inst_sram_resp;
  localparam int AW = 12;
  localparam int DEPTH = 1 << AW;
  localparam logic [31:0] BASE = 32'hbfc00000;
`ifdef INST_SRAM_WRITE_FIRST_EN
  localparam bit WF = 1'b1;
`else
  localparam bit WF = 1'b0;
`endif
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic init_done, addr_err;
  inst_sram_resp_if bus ();
  inst_sram_resp #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .init_done(init_done), .addr_err(addr_err));
  always #5 clk = ~clk;
  int vectors = 0;
  int fails = 0;
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_rdata;
  bit m_err, m_ready;
  int m_left;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(string tag);
    chk({tag, ":rdata"}, bus.inst_sram_rdata, m_rdata);
    chk({tag, ":err"}, {31'b0, addr_err}, {31'b0, m_err});
    chk({tag, ":done"}, {31'b0, init_done}, {31'b0, m_ready});
  endtask
  task automatic m_reset();
    foreach (m_mem[i]) m_mem[i] = 32'h0;
    m_rdata = 32'h0;
    m_err = 1'b0;
    m_ready = 1'b0;
    m_left = DEPTH;
  endtask
  task automatic drive(logic en, logic [3:0] wen, logic [31:0] addr, logic [31:0] wdata);
    bus.inst_sram_en = en;
    bus.inst_sram_wen = wen;
    bus.inst_sram_addr = addr;
    bus.inst_sram_wdata = wdata;
  endtask
  task automatic tick(string tag);
    logic en;
    logic [3:0] wen;
    logic [31:0] addr, wdata, off, old, mask, nw;
    en = bus.inst_sram_en;
    wen = bus.inst_sram_wen;
    addr = bus.inst_sram_addr;
    wdata = bus.inst_sram_wdata;
    @(posedge clk);
    #1;
    if (!m_ready) begin
      if (en) m_rdata = 32'h0;
      m_left--;
      if (m_left == 0) m_ready = 1'b1;
    end else if (en) begin
      off = addr - BASE;
      if (off >= 32'(4 * DEPTH) || off % 4 != 0) begin
        m_rdata = 32'h0;
        m_err = 1'b1;
      end else begin
        old = m_mem[off / 4];
        mask = {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
        nw = (old & ~mask) | (wdata & mask);
        m_mem[off / 4] = nw;
        m_rdata = (wen != 4'h0 && WF) ? nw : old;
      end
    end
    chk_all(tag);
  endtask
  task automatic step(string tag, logic en, logic [3:0] wen, logic [31:0] addr, logic [31:0] wdata);
    drive(en, wen, addr, wdata);
    tick(tag);
  endtask
  function automatic logic [31:0] rand_addr(bit bad);
    int k;
    k = $urandom_range(0, 19);
    if (bad && k >= 18) begin
      case ($urandom_range(0, 3))
        0: return BASE + 32'(4 * DEPTH);
        1: return BASE - 32'd4;
        2: return BASE + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
        default: return $urandom;
      endcase
    end
    if (k >= 16) return BASE + 32'(4 * (DEPTH - 1)) - 4 * $urandom_range(0, 3);
    return BASE + 4 * $urandom_range(0, 15);
  endfunction
  task automatic rand_step(string tag, bit bad);
    logic [3:0] wen;
    wen = $urandom_range(0, 1) != 0 ? 4'($urandom_range(1, 15)) : 4'h0;
    step(tag, $urandom_range(0, 9) != 0, wen, rand_addr(bad), $urandom);
  endtask
  initial begin
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    m_reset();
    #1;
    chk_all("reset");
    #3 resetn = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick("init");
    step("rd_base", 1'b1, 4'h0, BASE, 32'h0);
    chk("rd_base_k", bus.inst_sram_rdata, 32'h0);
    step("wr_4", 1'b1, 4'hf, BASE + 32'd4, 32'h3c1d0000);
    step("rd_4", 1'b1, 4'h0, BASE + 32'd4, 32'h0);
    chk("rd_4_k", bus.inst_sram_rdata, 32'h3c1d0000);
    step("wr_8", 1'b1, 4'hf, BASE + 32'd8, 32'h11223344);
    step("wr_8_part", 1'b1, 4'b0101, BASE + 32'd8, 32'haabbccdd);
    chk("wr_8_part_k", bus.inst_sram_rdata, WF ? 32'h11bb33dd : 32'h11223344);
    step("rd_8", 1'b1, 4'h0, BASE + 32'd8, 32'h0);
    chk("rd_8_k", bus.inst_sram_rdata, 32'h11bb33dd);
    for (int i = 0; i < 1200; i++) rand_step("rand_ok", 1'b0);
    step("wr_top", 1'b1, 4'hf, BASE + 32'(4 * (DEPTH - 1)), 32'hcafef00d);
    step("wr_0", 1'b1, 4'hf, BASE, 32'h01020304);
    step("rd_4b", 1'b1, 4'h0, BASE + 32'd4, 32'h0);
    step("mis_rd", 1'b1, 4'h0, BASE + 32'd2, 32'h0);
    chk("mis_err_k", {31'b0, addr_err}, 32'h1);
    step("low_rd", 1'b1, 4'h0, 32'hbfbffffc, 32'h0);
    step("hi_wr", 1'b1, 4'hf, BASE + 32'(4 * DEPTH), 32'hdeadbeef);
    step("mis_wr", 1'b1, 4'hf, BASE + 32'd5, 32'hdeadbeef);
    for (int i = 0; i < 3; i++) step("hold", 1'b0, 4'hf, BASE + 32'd4, 32'h12345678);
    chk("hold_k", bus.inst_sram_rdata, 32'h0);
    step("rd_0", 1'b1, 4'h0, BASE, 32'h0);
    chk("rd_0_k", bus.inst_sram_rdata, 32'h01020304);
    step("rd_top", 1'b1, 4'h0, BASE + 32'(4 * (DEPTH - 1)), 32'h0);
    step("rd_4c", 1'b1, 4'h0, BASE + 32'd4, 32'h0);
    for (int i = 0; i < 1200; i++) rand_step("rand_mix", 1'b1);
    resetn = 1'b0;
    m_reset();
    #1;
    chk_all("rst2");
    resetn = 1'b1;
    for (int i = 0; i < 100; i++) rand_step("init100", 1'b1);
    resetn = 1'b0;
    m_reset();
    #1;
    chk_all("rst_mid_init");
    resetn = 1'b1;
    for (int i = 0; i < DEPTH; i++) rand_step("init_busy", 1'b1);
    step("wr_40", 1'b1, 4'hf, BASE + 32'h40, 32'h5a5aa5a5);
    step("bad", 1'b1, 4'h0, BASE + 32'd1, 32'h0);
    step("rd_40", 1'b1, 4'h0, BASE + 32'h40, 32'h0);
    chk("rd_40_k", bus.inst_sram_rdata, 32'h5a5aa5a5);
    drive(1'b1, 4'hf, BASE + 32'h44, 32'h77778888);
    #3 resetn = 1'b0;
    m_reset();
    #1;
    chk_all("rst_mid_wr");
    #2 resetn = 1'b1;
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < DEPTH; i++) tick("init3");
    step("rd_40z", 1'b1, 4'h0, BASE + 32'h40, 32'h0);
    chk("rd_40z_k", bus.inst_sram_rdata, 32'h0);
    step("rd_44z", 1'b1, 4'h0, BASE + 32'h44, 32'h0);
    chk("rd_44z_k", bus.inst_sram_rdata, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
